// File: rtl/cluster_pwr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cluster_pwr_pkg
// Brief    : State encoding, output bundle and default timings for the cluster
//            power sequencer.
// Revision : 1.0
// ============================================================================
package cluster_pwr_pkg;

  localparam int unsigned C_SW_WAIT_CYCLES_DEF = 16;
  localparam int unsigned C_STEP_CYCLES_DEF    = 4;
  localparam int unsigned C_TIMEOUT_CYCLES_DEF = 255;

  localparam logic [3:0] C_ST_OFF    = 4'd0;
  localparam logic [3:0] C_ST_SW_UP  = 4'd1;
  localparam logic [3:0] C_ST_ISO_UP = 4'd2;
  localparam logic [3:0] C_ST_RST_UP = 4'd3;
  localparam logic [3:0] C_ST_ON     = 4'd4;
  localparam logic [3:0] C_ST_CLK_DN = 4'd5;
  localparam logic [3:0] C_ST_RST_DN = 4'd6;
  localparam logic [3:0] C_ST_ISO_DN = 4'd7;
  localparam logic [3:0] C_ST_SW_DN  = 4'd8;

  typedef enum logic [3:0] {
    ST_OFF    = C_ST_OFF,
    ST_SW_UP  = C_ST_SW_UP,
    ST_ISO_UP = C_ST_ISO_UP,
    ST_RST_UP = C_ST_RST_UP,
    ST_ON     = C_ST_ON,
    ST_CLK_DN = C_ST_CLK_DN,
    ST_RST_DN = C_ST_RST_DN,
    ST_ISO_DN = C_ST_ISO_DN,
    ST_SW_DN  = C_ST_SW_DN
  } cluster_pwr_state_e;

  typedef struct packed {
    logic ack;
    logic busy;
    logic sw_en;
    logic clamp;
    logic rst_n;
    logic clk_en;
  } cluster_pwr_out_t;

  // Every output is a pure function of the state being entered, so the
  // registered outputs are loaded from the next state on each edge.
  function automatic cluster_pwr_out_t pwr_outputs(cluster_pwr_state_e st);
    cluster_pwr_out_t o;
    o = '{ack: 1'b0, busy: 1'b0, sw_en: 1'b0, clamp: 1'b1, rst_n: 1'b0, clk_en: 1'b0};
    case (st)
      ST_SW_UP:  o = '{ack: 1'b0, busy: 1'b1, sw_en: 1'b1, clamp: 1'b1, rst_n: 1'b0, clk_en: 1'b0};
      ST_ISO_UP: o = '{ack: 1'b0, busy: 1'b1, sw_en: 1'b1, clamp: 1'b0, rst_n: 1'b0, clk_en: 1'b0};
      ST_RST_UP: o = '{ack: 1'b0, busy: 1'b1, sw_en: 1'b1, clamp: 1'b0, rst_n: 1'b1, clk_en: 1'b0};
      ST_ON:     o = '{ack: 1'b1, busy: 1'b0, sw_en: 1'b1, clamp: 1'b0, rst_n: 1'b1, clk_en: 1'b1};
      ST_CLK_DN: o = '{ack: 1'b1, busy: 1'b1, sw_en: 1'b1, clamp: 1'b0, rst_n: 1'b1, clk_en: 1'b0};
      ST_RST_DN: o = '{ack: 1'b1, busy: 1'b1, sw_en: 1'b1, clamp: 1'b0, rst_n: 1'b0, clk_en: 1'b0};
      ST_ISO_DN: o = '{ack: 1'b1, busy: 1'b1, sw_en: 1'b1, clamp: 1'b1, rst_n: 1'b0, clk_en: 1'b0};
      ST_SW_DN:  o = '{ack: 1'b1, busy: 1'b1, sw_en: 1'b0, clamp: 1'b1, rst_n: 1'b0, clk_en: 1'b0};
      default:   o = '{ack: 1'b0, busy: 1'b0, sw_en: 1'b0, clamp: 1'b1, rst_n: 1'b0, clk_en: 1'b0};
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cluster_pwr_sync.sv
`default_nettype none
// ============================================================================
// Module   : cluster_pwr_sync
// Brief    : Two-flop synchronizer, resets to 0.
// Revision : 1.0
// ============================================================================
module cluster_pwr_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule
`default_nettype wire

// File: rtl/cluster_pwr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cluster_pwr_sequencer
// Brief    : Ordered power-switch / clamp / reset / clock sequencing for the
//            cluster. Define CLUSTER_PWR_SW_ACK_EN to wait on the switch ack.
// Revision : 1.0
// ============================================================================
module cluster_pwr_sequencer
  import cluster_pwr_pkg::*;
#(
  parameter int unsigned DLY_W          = 8,
  parameter int unsigned SW_WAIT_CYCLES = C_SW_WAIT_CYCLES_DEF,
  parameter int unsigned STEP_CYCLES    = C_STEP_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = C_TIMEOUT_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pwr_req_i,
  output logic pwr_ack_o,
  output logic pwr_busy_o,
  output logic pwr_sw_en_o,
  input  logic pwr_sw_ack_i,
  output logic clamp_o,
  output logic cluster_rst_no,
  output logic cluster_clk_en_o,
  output logic err_o
);

  if (STEP_CYCLES < 1) begin : g_chk_step
    $error("cluster_pwr_sequencer: STEP_CYCLES must be at least 1");
  end
  if ((SW_WAIT_CYCLES < 1) || (SW_WAIT_CYCLES > (2**DLY_W) - 1)) begin : g_chk_sw_wait
    $error("cluster_pwr_sequencer: SW_WAIT_CYCLES does not fit in DLY_W");
  end
  if (TIMEOUT_CYCLES > (2**DLY_W) - 1) begin : g_chk_timeout
    $error("cluster_pwr_sequencer: TIMEOUT_CYCLES does not fit in DLY_W");
  end

  localparam logic [DLY_W-1:0] C_STEP_LAST = DLY_W'(STEP_CYCLES - 1);

  cluster_pwr_state_e r_state;
  cluster_pwr_state_e w_state_nxt;
  cluster_pwr_out_t   r_out;
  logic [DLY_W-1:0]   r_cnt;
  logic               r_err;
  logic               w_err_nxt;
  logic               w_step_done;
  logic               w_sw_up_done;
  logic               w_sw_dn_done;
  logic               w_sw_timeout;

  assign w_step_done = (r_cnt == C_STEP_LAST);

`ifdef CLUSTER_PWR_SW_ACK_EN
  // Fires on the edge where the counter steps onto TIMEOUT_CYCLES-1.
  localparam logic [DLY_W-1:0] C_TO_HIT =
    DLY_W'((TIMEOUT_CYCLES >= 2) ? (TIMEOUT_CYCLES - 2) : 0);

  logic w_ack_sync;

  cluster_pwr_sync u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pwr_sw_ack_i),
    .q_o    (w_ack_sync)
  );

  assign w_sw_up_done = w_ack_sync;
  assign w_sw_dn_done = !w_ack_sync;
  assign w_sw_timeout = (r_cnt == C_TO_HIT);
`else
  localparam logic [DLY_W-1:0] C_SW_LAST = DLY_W'(SW_WAIT_CYCLES - 1);

  logic w_unused_sw_ack;
  assign w_unused_sw_ack = pwr_sw_ack_i;

  assign w_sw_up_done = (r_cnt == C_SW_LAST);
  assign w_sw_dn_done = (r_cnt == C_SW_LAST);
  assign w_sw_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    case (r_state)
      ST_OFF: begin
        if (!pwr_req_i) begin
          w_err_nxt = 1'b0;
        end else if (!r_err) begin
          w_state_nxt = ST_SW_UP;
        end
      end
      ST_SW_UP: begin
        if (w_sw_up_done) begin
          w_state_nxt = ST_ISO_UP;
        end else if (w_sw_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_OFF;
        end
      end
      ST_ISO_UP: if (w_step_done) w_state_nxt = ST_RST_UP;
      ST_RST_UP: if (w_step_done) w_state_nxt = ST_ON;
      ST_ON:     if (!pwr_req_i)  w_state_nxt = ST_CLK_DN;
      ST_CLK_DN: if (w_step_done) w_state_nxt = ST_RST_DN;
      ST_RST_DN: if (w_step_done) w_state_nxt = ST_ISO_DN;
      ST_ISO_DN: if (w_step_done) w_state_nxt = ST_SW_DN;
      ST_SW_DN: begin
        if (w_sw_dn_done) begin
          w_state_nxt = ST_OFF;
        end else if (w_sw_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_OFF;
        end
      end
      default: w_state_nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_out   <= pwr_outputs(ST_OFF);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
      r_err   <= w_err_nxt;
      r_out   <= pwr_outputs(w_state_nxt);
    end
  end

  assign pwr_ack_o        = r_out.ack;
  assign pwr_busy_o       = r_out.busy;
  assign pwr_sw_en_o      = r_out.sw_en;
  assign clamp_o          = r_out.clamp;
  assign cluster_rst_no   = r_out.rst_n;
  assign cluster_clk_en_o = r_out.clk_en;
  assign err_o            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cluster_pwr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cluster_pwr_sequencer
// Brief    : Directed self-checking bench for cluster_pwr_sequencer.
// Revision : 1.0
// ============================================================================
module tb_cluster_pwr_sequencer;

  // Observed vector order: {ack, busy, sw_en, clamp, rst_n, clk_en, err}
  localparam logic [6:0] V_OFF    = 7'b0001000;
  localparam logic [6:0] V_SW_UP  = 7'b0111000;
  localparam logic [6:0] V_ISO_UP = 7'b0110000;
  localparam logic [6:0] V_RST_UP = 7'b0110100;
  localparam logic [6:0] V_ON     = 7'b1010110;
  localparam logic [6:0] V_CLK_DN = 7'b1110100;
  localparam logic [6:0] V_RST_DN = 7'b1110000;
  localparam logic [6:0] V_ISO_DN = 7'b1111000;
  localparam logic [6:0] V_SW_DN  = 7'b1101000;
  localparam logic [6:0] V_ERR    = 7'b0001001;

  logic clk;
  logic rst_n;
  logic req;
  logic sw_ack;
  logic ack, busy, sw_en, clamp, crst_n, clk_en, err;

  typedef struct {
    int         at;
    logic [6:0] vec;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  cluster_pwr_sequencer dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .pwr_req_i        (req),
    .pwr_ack_o        (ack),
    .pwr_busy_o       (busy),
    .pwr_sw_en_o      (sw_en),
    .pwr_sw_ack_i     (sw_ack),
    .clamp_o          (clamp),
    .cluster_rst_no   (crst_n),
    .cluster_clk_en_o (clk_en),
    .err_o            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {ack, busy, sw_en, clamp, crst_n, clk_en, err};
  endfunction

  task automatic check(input string tag, input logic [6:0] o, input logic [6:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic push(input int at, input logic [6:0] vec, input string tag);
    exp_t x;
    x.at  = at;
    x.vec = vec;
    x.tag = tag;
    sb.push_back(x);
  endtask

  // Edge indices first..first+n-1; each edge is sampled 1 ns after it.
  task automatic run(input int first, input int n);
    exp_t x;
    for (int k = first; k < first + n; k++) begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].at == k) begin
        x = sb.pop_front();
        check(x.tag, obs(), x.vec);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_async", obs(), V_OFF);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = 1'b0;
    sw_ack = 1'b0;
    #12;
    check("reset", obs(), V_OFF);
    @(negedge clk);
    rst_n = 1'b1;
    push(2, V_OFF, "idle_off");
    run(0, 3);

`ifndef CLUSTER_PWR_SW_ACK_EN
    // Power-up with defaults.
    req = 1'b1;
    push(0,  V_SW_UP,  "up_sw_en");
    push(15, V_SW_UP,  "up_still_clamped");
    push(16, V_ISO_UP, "up_clamp_rel");
    push(19, V_ISO_UP, "up_rst_held");
    push(20, V_RST_UP, "up_rst_rel");
    push(23, V_RST_UP, "up_busy_last");
    push(24, V_ON,     "up_on");
    push(30, V_ON,     "on_steady");
    run(0, 31);

    // Power-down from ON.
    req = 1'b0;
    push(0,  V_CLK_DN, "dn_clk_off");
    push(3,  V_CLK_DN, "dn_rst_held");
    push(4,  V_RST_DN, "dn_rst_on");
    push(8,  V_ISO_DN, "dn_clamp_on");
    push(12, V_SW_DN,  "dn_sw_off");
    push(27, V_SW_DN,  "dn_ack_held");
    push(28, V_OFF,    "dn_off");
    push(32, V_OFF,    "off_steady");
    run(0, 33);

    // Request drops during power-up: sequence completes, then powers down.
    req = 1'b1;
    push(0,  V_SW_UP,  "drop_sw_en");
    run(0, 10);
    req = 1'b0;
    push(16, V_ISO_UP, "drop_clamp_rel");
    push(24, V_ON,     "drop_on");
    push(25, V_CLK_DN, "drop_clk_off");
    run(10, 16);
    push(28, V_OFF,    "drop_off");
    run(0, 29);

    // Async reset mid-clock while in ISO_UP.
    req = 1'b1;
    push(17, V_ISO_UP, "ar_in_iso");
    run(0, 18);
    #2;
    req = 1'b0;
    do_reset();
    push(3, V_OFF, "ar_stays_off");
    run(0, 4);
    req = 1'b1;
    push(0, V_SW_UP, "ar_restart");
    run(0, 1);
    req = 1'b0;
    do_reset();
`else
    // Switch ack returns during cycle 5.
    req = 1'b1;
    push(0, V_SW_UP,  "ack_sw_en");
    push(6, V_SW_UP,  "ack_still_clamped");
    push(8, V_ISO_UP, "ack_clamp_rel");
    run(0, 5);
    sw_ack = 1'b1;
    run(5, 4);
    req    = 1'b0;
    sw_ack = 1'b0;
    do_reset();

    // Ack never returns: timeout.
    req = 1'b1;
    push(0,   V_SW_UP, "to_sw_en");
    push(253, V_SW_UP, "to_before");
    push(254, V_ERR,   "to_err");
    push(258, V_ERR,   "to_no_restart");
    run(0, 259);
    req = 1'b0;
    push(0, V_OFF, "to_err_clear");
    run(0, 1);
`endif

    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
